// File: rtl/serial_pkg.sv
// Shared definitions for the UART-style serial transmit controller:
// frame geometry and the 2-bit FSM state encoding.
package serial_pkg;

    localparam int unsigned FRAME_BITS = 10;
    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned CNT_W      = $clog2(DATA_BITS);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    typedef enum logic [1:0] {
        StIdle  = ST_IDLE,
        StStart = ST_START,
        StData  = ST_DATA,
        StStop  = ST_STOP
    } tx_state_e;

endpackage

// File: rtl/shift_reg8_en.sv
// 8-bit parallel-load / shift-right register with a hold enable.
// S_L=1 loads p_in, S_L=0 shifts right taking s_in into the MSB.
module shift_reg8_en (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       S_L,
    input  logic       s_in,
    input  logic [7:0] p_in,
    output logic [7:0] Q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Q <= 8'hFF;
        end else if (en) begin
            if (S_L) begin
                Q <= p_in;
            end else begin
                Q <= {s_in, Q[7:1]};
            end
        end
    end

endmodule

// File: rtl/serial_tx_ctrl.sv
// Serializes bytes as start + 8 data bits (LSB first) + stop, one bit every CLK_DIV clocks.
// Outputs are decoded purely from registered state, so no input reaches an output combinationally.
module serial_tx_ctrl
    import serial_pkg::*;
#(
    parameter int unsigned CLK_DIV = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_out,
    output logic       busy,
    output logic       done
);

    localparam int unsigned DIV_W = $clog2(CLK_DIV + 1);

    tx_state_e        state_q;
    logic [DIV_W-1:0] div_q;
    logic [CNT_W-1:0] bit_cnt_q;
    logic             done_q;
    logic [7:0]       shreg_q;
    logic             div_wrap;
    logic             accept;
    logic             sr_en;
    logic             unused_shreg_hi;

    assign div_wrap = (div_q == DIV_W'(CLK_DIV - 1));
    assign accept   = (state_q == StIdle) && tx_valid;
    // Load on accept, shift once per bit period while sending data bits.
    assign sr_en    = accept || ((state_q == StData) && div_wrap);

    shift_reg8_en u_shreg (
        .clk  (clk),
        .rst  (rst),
        .en   (sr_en),
        .S_L  (accept),
        .s_in (1'b1),
        .p_in (tx_data),
        .Q    (shreg_q)
    );

    assign unused_shreg_hi = ^shreg_q[7:1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            div_q     <= '0;
            bit_cnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (tx_valid) begin
                        state_q   <= StStart;
                        div_q     <= '0;
                        bit_cnt_q <= '0;
                    end
                end
                StStart: begin
                    if (div_wrap) begin
                        div_q   <= '0;
                        state_q <= StData;
                    end else begin
                        div_q <= div_q + DIV_W'(1);
                    end
                end
                StData: begin
                    if (div_wrap) begin
                        div_q <= '0;
                        if (bit_cnt_q == CNT_W'(DATA_BITS - 1)) begin
                            bit_cnt_q <= '0;
                            state_q   <= StStop;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        end
                    end else begin
                        div_q <= div_q + DIV_W'(1);
                    end
                end
                StStop: begin
                    if (div_wrap) begin
                        div_q   <= '0;
                        state_q <= StIdle;
                        done_q  <= 1'b1;
                    end else begin
                        div_q <= div_q + DIV_W'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign tx_ready = (state_q == StIdle);
    assign busy     = (state_q != StIdle);
    assign done     = done_q;

    always_comb begin
        tx_out = 1'b1;
        case (state_q)
            StStart: tx_out = 1'b0;
            StData:  tx_out = shreg_q[0];
            default: tx_out = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_serial_tx_ctrl.sv
// Self-checking bench for serial_tx_ctrl: CLK_DIV=4 and CLK_DIV=1 instances,
// checked against a frame-level model of the expected serial line.
module tb_serial_tx_ctrl;
    import serial_pkg::*;

    logic       clk;
    logic       rst;
    logic [7:0] d4_data, d1_data;
    logic       d4_valid, d1_valid;
    logic       d4_ready, d4_out, d4_busy, d4_done;
    logic       d1_ready, d1_out, d1_busy, d1_done;
    int         total;
    int         bad;

    serial_tx_ctrl #(.CLK_DIV(4)) dut4 (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (d4_data),
        .tx_valid (d4_valid),
        .tx_ready (d4_ready),
        .tx_out   (d4_out),
        .busy     (d4_busy),
        .done     (d4_done)
    );

    serial_tx_ctrl #(.CLK_DIV(1)) dut1 (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (d1_data),
        .tx_valid (d1_valid),
        .tx_ready (d1_ready),
        .tx_out   (d1_out),
        .busy     (d1_busy),
        .done     (d1_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected line level k cycles after the accept edge.
    function automatic logic exp_line(input logic [7:0] b, input int k, input int div);
        logic [FRAME_BITS-1:0] frame;
        int idx;
        frame = {1'b1, b, 1'b0};
        idx = k / div;
        if (idx >= int'(FRAME_BITS)) return 1'b1;
        return frame[idx];
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        d4_valid = 1'b0; d4_data = 8'h00;
        d1_valid = 1'b0; d1_data = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({d4_done, d4_busy, d4_ready, d4_out} !== 4'b0011) begin
            bad++;
            $display("FAIL reset_held4 got=%b want=0011", {d4_done, d4_busy, d4_ready, d4_out});
        end
        rst = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            total++;
            if ({d4_done, d4_busy, d4_ready, d4_out, d1_done, d1_busy, d1_ready, d1_out}
                    !== 8'b0011_0011) begin
                bad++;
                $display("FAIL reset_idle c=%0d got=%b want=00110011", c,
                         {d4_done, d4_busy, d4_ready, d4_out, d1_done, d1_busy, d1_ready, d1_out});
            end
        end
    endtask

    task automatic test_a5();
        @(negedge clk);
        d4_valid = 1'b1; d4_data = 8'hA5;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            d4_valid = 1'b0;
            total++;
            if (d4_out !== exp_line(8'hA5, k, 4)) begin
                bad++;
                $display("FAIL a5_line k=%0d got=%b want=%b", k, d4_out, exp_line(8'hA5, k, 4));
            end
            total++;
            if ({d4_done, d4_busy, d4_ready} !== 3'b010) begin
                bad++;
                $display("FAIL a5_busy k=%0d got=%b want=010", k, {d4_done, d4_busy, d4_ready});
            end
        end
        @(negedge clk);
        total++;
        if ({d4_done, d4_busy, d4_ready, d4_out} !== 4'b1011) begin
            bad++;
            $display("FAIL a5_done got=%b want=1011", {d4_done, d4_busy, d4_ready, d4_out});
        end
        @(negedge clk);
        total++;
        if ({d4_done, d4_busy, d4_ready, d4_out} !== 4'b0011) begin
            bad++;
            $display("FAIL a5_after got=%b want=0011", {d4_done, d4_busy, d4_ready, d4_out});
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        for (int n = 0; n < 6; n++) begin
            repeat ($urandom_range(3, 0)) @(negedge clk);
            b = 8'($urandom);
            @(negedge clk);
            d4_valid = 1'b1; d4_data = b;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                d4_valid = 1'b0;
                d4_data = 8'($urandom);
                total++;
                if ({d4_out, d4_busy, d4_done} !== {exp_line(b, k, 4), 2'b10}) begin
                    bad++;
                    $display("FAIL rand_line b=%h k=%0d got=%b want=%b", b, k,
                             {d4_out, d4_busy, d4_done}, {exp_line(b, k, 4), 2'b10});
                end
            end
            @(negedge clk);
            total++;
            if ({d4_done, d4_busy, d4_ready, d4_out} !== 4'b1011) begin
                bad++;
                $display("FAIL rand_done b=%h got=%b want=1011", b,
                         {d4_done, d4_busy, d4_ready, d4_out});
            end
        end
    endtask

    task automatic test_back_to_back();
        int done_seen;
        done_seen = 0;
        @(negedge clk);
        d4_valid = 1'b1; d4_data = 8'h00;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 0) d4_data = 8'hFF;
            total++;
            if ({d4_out, d4_busy, d4_done} !== {exp_line(8'h00, k, 4), 2'b10}) begin
                bad++;
                $display("FAIL b2b_f1 k=%0d got=%b want=%b", k, {d4_out, d4_busy, d4_done},
                         {exp_line(8'h00, k, 4), 2'b10});
            end
        end
        @(negedge clk);
        total++;
        if ({d4_done, d4_busy, d4_ready, d4_out} !== 4'b1011) begin
            bad++;
            $display("FAIL b2b_gap got=%b want=1011", {d4_done, d4_busy, d4_ready, d4_out});
        end
        for (int k = 0; k < 41; k++) begin
            @(negedge clk);
            d4_valid = 1'b0;
            if (d4_done === 1'b1) done_seen = k + 1;
            if (k < 40) begin
                total++;
                if ({d4_out, d4_busy} !== {exp_line(8'hFF, k, 4), 1'b1}) begin
                    bad++;
                    $display("FAIL b2b_f2 k=%0d got=%b want=%b", k, {d4_out, d4_busy},
                             {exp_line(8'hFF, k, 4), 1'b1});
                end
            end
        end
        total++;
        if (done_seen !== 41) begin
            bad++;
            $display("FAIL b2b_done_spacing got=%0d want=41", done_seen);
        end
    endtask

    task automatic test_ignored();
        @(negedge clk);
        d4_valid = 1'b1; d4_data = 8'h3C;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            d4_valid = (k < 38) ? 1'(k % 2) : 1'b0;
            if (k == 10) d4_data = 8'hFF;
            total++;
            if ({d4_out, d4_busy, d4_done} !== {exp_line(8'h3C, k, 4), 2'b10}) begin
                bad++;
                $display("FAIL ign_line k=%0d got=%b want=%b", k, {d4_out, d4_busy, d4_done},
                         {exp_line(8'h3C, k, 4), 2'b10});
            end
        end
        @(negedge clk);
        total++;
        if ({d4_done, d4_busy, d4_ready, d4_out} !== 4'b1011) begin
            bad++;
            $display("FAIL ign_done got=%b want=1011", {d4_done, d4_busy, d4_ready, d4_out});
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if ({d4_done, d4_busy, d4_ready, d4_out} !== 4'b0011) begin
                bad++;
                $display("FAIL ign_no_restart c=%0d got=%b want=0011", c,
                         {d4_done, d4_busy, d4_ready, d4_out});
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        d4_valid = 1'b1; d4_data = 8'h3C;
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            d4_valid = 1'b0;
            total++;
            if (d4_out !== exp_line(8'h3C, k, 4)) begin
                bad++;
                $display("FAIL rmid_pre k=%0d got=%b want=%b", k, d4_out, exp_line(8'h3C, k, 4));
            end
        end
        rst = 1'b1;
        #1;
        total++;
        if ({d4_done, d4_busy, d4_ready, d4_out} !== 4'b0011) begin
            bad++;
            $display("FAIL rmid_async got=%b want=0011", {d4_done, d4_busy, d4_ready, d4_out});
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            total++;
            if ({d4_done, d4_busy, d4_ready, d4_out} !== 4'b0011) begin
                bad++;
                $display("FAIL rmid_quiet c=%0d got=%b want=0011", c,
                         {d4_done, d4_busy, d4_ready, d4_out});
            end
        end
        @(negedge clk);
        d4_valid = 1'b1; d4_data = 8'h5A;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            d4_valid = 1'b0;
            total++;
            if ({d4_out, d4_busy, d4_done} !== {exp_line(8'h5A, k, 4), 2'b10}) begin
                bad++;
                $display("FAIL rmid_5a k=%0d got=%b want=%b", k, {d4_out, d4_busy, d4_done},
                         {exp_line(8'h5A, k, 4), 2'b10});
            end
        end
        @(negedge clk);
        total++;
        if ({d4_done, d4_busy, d4_ready, d4_out} !== 4'b1011) begin
            bad++;
            $display("FAIL rmid_5a_done got=%b want=1011", {d4_done, d4_busy, d4_ready, d4_out});
        end
    endtask

    task automatic test_div1();
        logic [7:0] b;
        for (int n = 0; n < 4; n++) begin
            b = (n == 0) ? 8'h81 : 8'($urandom);
            @(negedge clk);
            d1_valid = 1'b1; d1_data = b;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                d1_valid = 1'b0;
                total++;
                if ({d1_out, d1_busy, d1_done} !== {exp_line(b, k, 1), 2'b10}) begin
                    bad++;
                    $display("FAIL div1_line b=%h k=%0d got=%b want=%b", b, k,
                             {d1_out, d1_busy, d1_done}, {exp_line(b, k, 1), 2'b10});
                end
            end
            @(negedge clk);
            total++;
            if ({d1_done, d1_busy, d1_ready, d1_out} !== 4'b1011) begin
                bad++;
                $display("FAIL div1_done b=%h got=%b want=1011", b,
                         {d1_done, d1_busy, d1_ready, d1_out});
            end
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_a5();
        test_random();
        test_back_to_back();
        test_ignored();
        test_div1();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
